// File: rtl/msx_input_pkg.sv
// msx_input_pkg: shared types and helpers for the MSX general-purpose input ports.
//   nib_state_t : nibble sequencer states, in transmit order.
//   DELTA_W     : width of one mouse delta as seen by the MSX (8 bits).
//   sat8        : clamp a 10-bit signed value to the signed 8-bit range.
package msx_input_pkg;

   typedef enum logic [1:0] {
      NIB_XH,
      NIB_XL,
      NIB_YH,
      NIB_YL
   } nib_state_t;

   localparam int DELTA_W = 8;

   function automatic logic signed [DELTA_W-1:0] sat8(input logic signed [DELTA_W+1:0] v);
      if (v > 10'sd127)
         return 8'sd127;
      else if (v < -10'sd128)
         return -8'sd128;
      else
         return v[DELTA_W-1:0];
   endfunction

endpackage

// File: rtl/msx_mouse_codec.sv
// msx_mouse_codec: turns host mouse packets into the MSX 4-nibble mouse protocol.
//   clk_sys, reset         : clock, synchronous active-high reset
//   clr                    : abandon the nibble sequence (mouse moved to another port)
//   mouse_x, mouse_y       : signed 9-bit host deltas
//   mouse_strobe           : one-cycle new-packet pulse
//   str                    : strobe pin of the port the mouse sits on
//   nibble                 : value for pins 3:0; the new nibble in an edge cycle, else held
// Build option: MSX_MOUSE_ACCUM_EN defined -> packets accumulate with saturation;
// undefined -> each packet overwrites the accumulators.
module msx_mouse_codec
   import msx_input_pkg::*;
#(
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              clr,
   input  logic signed [8:0] mouse_x,
   input  logic signed [8:0] mouse_y,
   input  logic              mouse_strobe,
   input  logic              str,
   output logic [3:0]        nibble
);

   localparam int CW = $clog2(TIMEOUT + 1);

   nib_state_t               state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [3:0]               hold_q, hold_d, cur;
   logic                     str_d, str_edge, yl_clear;
   logic signed [DELTA_W-1:0] dx, dy, acc_x, acc_y, upd_x, upd_y;
   logic signed [DELTA_W+1:0] neg_x;

   // MSX X axis runs opposite to the host's.
   always_comb begin
      neg_x = -$signed({mouse_x[8], mouse_x});
      dx    = sat8(neg_x);
      dy    = sat8({mouse_y[8], mouse_y});
   end

`ifdef MSX_MOUSE_ACCUM_EN
   logic signed [DELTA_W+1:0] sum_x, sum_y;
   always_comb begin
      sum_x = {acc_x[7], acc_x[7], acc_x} + {dx[7], dx[7], dx};
      sum_y = {acc_y[7], acc_y[7], acc_y} + {dy[7], dy[7], dy};
      upd_x = sat8(sum_x);
      upd_y = sat8(sum_y);
   end
`else
   always_comb begin
      upd_x = dx;
      upd_y = dy;
   end
`endif

   always_comb begin
      str_edge = (str != str_d);
      unique case (state_q)
         NIB_XH:  cur = acc_x[7:4];
         NIB_XL:  cur = acc_x[3:0];
         NIB_YH:  cur = acc_y[7:4];
         default: cur = acc_y[3:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      yl_clear = 1'b0;
      if (clr) begin
         state_d = NIB_XH;
         cnt_d   = '0;
         hold_d  = '0;
      end else if (str_edge) begin
         // An edge beats a simultaneous timeout expiry.
         hold_d   = cur;
         cnt_d    = CW'(TIMEOUT);
         yl_clear = (state_q == NIB_YL);
         unique case (state_q)
            NIB_XH:  state_d = NIB_XL;
            NIB_XL:  state_d = NIB_YH;
            NIB_YH:  state_d = NIB_YL;
            default: state_d = NIB_XH;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1))
            state_d = NIB_XH;
      end
      nibble = (str_edge && !clr) ? cur : hold_q;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= NIB_XH;
         cnt_q   <= '0;
         hold_q  <= '0;
         str_d   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         str_d   <= str;
      end
   end

   // A packet arriving with the post-YL clear replaces the cleared value, so it is never lost.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         acc_x <= '0;
         acc_y <= '0;
      end else if (yl_clear) begin
         acc_x <= mouse_strobe ? dx : '0;
         acc_y <= mouse_strobe ? dy : '0;
      end else if (mouse_strobe) begin
         acc_x <= upd_x;
         acc_y <= upd_y;
      end
   end

endmodule

// File: rtl/msx_input_ports.sv
// msx_input_ports: maps host joysticks and one host mouse onto NPORTS MSX joystick ports.
//   clk_sys, reset       : clock, synchronous active-high reset
//   joy_n                : host joystick bits, active-low, 6 per port (R,L,D,U,fire1,fire2)
//   mouse_x/y, flags     : host mouse packet; flags bit0 left, bit1 right button
//   mouse_strobe         : one-cycle new-packet pulse
//   mouse_port           : port the mouse is attached to
//   str                  : MSX strobe pin per port
//   port_n               : registered open-collector pin state, 0 = pulled low
//   mouse_active         : one-hot, port currently in mouse mode
// Build option: MSX_MOUSE_ACCUM_EN (see msx_mouse_codec).
module msx_input_ports
   import msx_input_pkg::*;
#(
   parameter int unsigned NPORTS  = 2,
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic [NPORTS*6-1:0]        joy_n,
   input  logic signed [8:0]          mouse_x,
   input  logic signed [8:0]          mouse_y,
   input  logic [7:0]                 mouse_flags,
   input  logic                       mouse_strobe,
   input  logic [$clog2(NPORTS)-1:0]  mouse_port,
   input  logic [NPORTS-1:0]          str,
   output logic [NPORTS*6-1:0]        port_n,
   output logic [NPORTS-1:0]          mouse_active
);

   localparam int PW = $clog2(NPORTS);

   logic [PW-1:0]       mouse_port_d;
   logic                mouse_en, port_chg, str_m;
   logic [5:0]          joy_m;
   logic [3:0]          nibble;
   logic [NPORTS*6-1:0] port_n_d;
   logic                unused_flags;

   assign unused_flags = ^mouse_flags[7:2];
   assign port_chg     = (mouse_port != mouse_port_d);

   msx_mouse_codec #(
      .TIMEOUT(TIMEOUT)
   ) u_codec (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .clr          (port_chg),
      .mouse_x      (mouse_x),
      .mouse_y      (mouse_y),
      .mouse_strobe (mouse_strobe),
      .str          (str_m),
      .nibble       (nibble)
   );

   always_comb begin
      joy_m        = '1;
      str_m        = 1'b0;
      mouse_active = '0;
      port_n_d     = '1;
      for (int unsigned p = 0; p < NPORTS; p++) begin
         if (mouse_port == PW'(p)) begin
            joy_m           = joy_n[6*p +: 6];
            str_m           = str[p];
            mouse_active[p] = mouse_en;
         end
         // A pin is pulled low only when the host asserts it and the strobe is low.
         if (mouse_en && mouse_port == PW'(p))
            port_n_d[6*p +: 6] = {~mouse_flags[1:0], nibble};
         else
            port_n_d[6*p +: 6] = joy_n[6*p +: 6] | {6{str[p]}};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         mouse_en     <= 1'b0;
         mouse_port_d <= '0;
         port_n       <= '1;
      end else begin
         mouse_port_d <= mouse_port;
         port_n       <= port_n_d;
         if (port_chg)
            mouse_en <= 1'b0;
         else if (mouse_strobe)
            mouse_en <= 1'b1;
         else if (joy_m != '1)
            mouse_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_msx_input_ports.sv
module tb_msx_input_ports;

   localparam int unsigned TO = 20;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic [11:0]       joy_n;
   logic signed [8:0] mouse_x, mouse_y;
   logic [7:0]        mouse_flags;
   logic              mouse_strobe;
   logic              mouse_port;
   logic [1:0]        str;
   logic [11:0]       port_n;
   logic [1:0]        mouse_active;

   msx_input_ports #(
      .NPORTS  (2),
      .TIMEOUT (TO)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .joy_n        (joy_n),
      .mouse_x      (mouse_x),
      .mouse_y      (mouse_y),
      .mouse_flags  (mouse_flags),
      .mouse_strobe (mouse_strobe),
      .mouse_port   (mouse_port),
      .str          (str),
      .port_n       (port_n),
      .mouse_active (mouse_active)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

`ifdef MSX_MOUSE_ACCUM_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif

   // Reference model state: protocol position 0..3, accumulators as plain integers.
   int m_idx, m_ax, m_ay, m_hold, m_last, m_en, m_strp;

   typedef struct {
      logic [11:0] joy;
      logic [1:0]  s;
      logic [11:0] exp;
   } joy_vec_t;

   task automatic step();
      @(posedge clk_sys);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clamp(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int pick(input int idx);
      case (idx)
         0: return (m_ax & 255) >> 4;
         1: return m_ax & 15;
         2: return (m_ay & 255) >> 4;
         default: return m_ay & 15;
      endcase
   endfunction

   task automatic do_reset(input bit chk);
      reset = 1'b1; joy_n = '1; str = '0; mouse_strobe = 1'b0;
      mouse_port = 1'b0; mouse_flags = '0; mouse_x = '0; mouse_y = '0;
      step(); step();
      if (chk) begin
         check("reset_port_n", port_n, 12'hFFF);
         check("reset_mouse_active", mouse_active, 2'b00);
      end
      reset = 1'b0;
      m_idx = 0; m_ax = 0; m_ay = 0; m_hold = 0; m_last = -1; m_en = 0; m_strp = 0;
   endtask

   // One cycle on port 0 with the mouse attached; checks pins against the model.
   task automatic mcycle(input bit stb, input int x, input int y, input bit tog, input int exp_nib);
      logic [7:0] fl;
      bit         edg;
      int         en_out, dx, dy;
      fl = 8'($urandom);
      mouse_strobe = stb; mouse_x = 9'(x); mouse_y = 9'(y); mouse_flags = fl;
      if (tog) str[0] = ~str[0];
      edg = (str[0] != m_strp[0]);
      m_strp = int'(str[0]);
      en_out = m_en;
      if (edg) begin
         if (m_last >= 0 && cyc - m_last > int'(TO)) m_idx = 0;
         m_hold = pick(m_idx);
         m_last = cyc;
      end
      dx = clamp(-x);
      dy = clamp(y);
      if (edg && m_idx == 3) begin
         m_ax = stb ? dx : 0;
         m_ay = stb ? dy : 0;
      end else if (stb) begin
         m_ax = ACC ? clamp(m_ax + dx) : dx;
         m_ay = ACC ? clamp(m_ay + dy) : dy;
      end
      if (edg) m_idx = (m_idx + 1) % 4;
      if (stb) m_en = 1;
      step();
      if (en_out != 0)
         check("mouse_pins", port_n[5:0], {~fl[1:0], 4'(m_hold)});
      else
         check("idle_pins", port_n[5:0], 6'h3F);
      check("mouse_active", mouse_active, (m_en != 0) ? 2'b01 : 2'b00);
      if (exp_nib >= 0)
         check("nibble_directed", port_n[3:0], exp_nib);
   endtask

   initial begin
      joy_vec_t vecs[6];
      logic [11:0] e;

      do_reset(1'b1);

      // Joystick gating table.
      vecs[0] = '{12'b111110_111111, 2'b00, 12'b111110_111111};
      vecs[1] = '{12'b111110_111111, 2'b10, 12'hFFF};
      vecs[2] = '{12'h000,           2'b00, 12'h000};
      vecs[3] = '{12'h000,           2'b01, 12'h03F};
      vecs[4] = '{12'h000,           2'b10, 12'hFC0};
      vecs[5] = '{12'b101010_010101, 2'b00, 12'b101010_010101};
      for (int i = 0; i < 6; i++) begin
         joy_n = vecs[i].joy; str = vecs[i].s;
         step();
         check($sformatf("joy_vec%0d", i), port_n, vecs[i].exp);
         check("joy_no_mouse", mouse_active, 2'b00);
      end

      // Random joystick traffic: a pin is low only if host bit low and strobe low.
      for (int i = 0; i < 30; i++) begin
         joy_n = 12'($urandom); str = 2'($urandom);
         for (int b = 0; b < 12; b++)
            e[b] = !(joy_n[b] == 1'b0 && str[b / 6] == 1'b0);
         step();
         check("joy_random", port_n, e);
      end

      // Basic mouse sequence: dx = 5, dy = 3.
      do_reset(1'b0);
      mcycle(1, -5, 3, 0, -1);
      mcycle(0, 0, 0, 1, 0);
      mcycle(0, 0, 0, 1, 5);
      mcycle(0, 0, 0, 1, 0);
      mcycle(0, 0, 0, 1, 3);
      mcycle(0, 0, 0, 1, 0);

      // Accumulation / overwrite of two x = -100 packets.
      do_reset(1'b0);
      mcycle(1, -100, 0, 0, -1);
      mcycle(1, -100, 0, 0, -1);
      mcycle(0, 0, 0, 1, ACC ? 7 : 6);
      mcycle(0, 0, 0, 1, ACC ? 15 : 4);

      // Timeout: gap of TO+1 restarts at XH.
      do_reset(1'b0);
      mcycle(1, -53, 18, 0, -1);
      mcycle(0, 0, 0, 1, 3);
      mcycle(0, 0, 0, 1, 5);
      for (int i = 0; i < int'(TO); i++) mcycle(0, 0, 0, 0, -1);
      mcycle(0, 0, 0, 1, 3);

      // Edge exactly at the expiry cycle advances normally.
      do_reset(1'b0);
      mcycle(1, -53, 18, 0, -1);
      mcycle(0, 0, 0, 1, 3);
      mcycle(0, 0, 0, 1, 5);
      for (int i = 0; i < int'(TO) - 1; i++) mcycle(0, 0, 0, 0, -1);
      mcycle(0, 0, 0, 1, 1);

      // Collision: packet arriving with the YL edge survives the clear.
      do_reset(1'b0);
      mcycle(1, -18, 52, 0, -1);
      mcycle(0, 0, 0, 1, 1);
      mcycle(0, 0, 0, 1, 2);
      mcycle(0, 0, 0, 1, 3);
      mcycle(1, -86, 120, 1, 4);
      mcycle(0, 0, 0, 1, 5);
      mcycle(0, 0, 0, 1, 6);

      // Randomized mouse traffic against the model.
      do_reset(1'b0);
      mcycle(1, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, 0, -1);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0)
            for (int k = 0; k < 25; k++) mcycle(0, 0, 0, 0, -1);
         mcycle($urandom_range(0, 3) == 0,
                int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                $urandom_range(0, 2) == 0, -1);
      end

      // Handover between ports.
      do_reset(1'b0);
      mouse_strobe = 1'b1; step();
      mouse_strobe = 1'b0; step();
      check("handover_active_p0", mouse_active, 2'b01);
      joy_n[4] = 1'b0; step();
      check("handover_joy_clears", mouse_active, 2'b00);
      step();
      check("handover_joy_gating", port_n[5:0], 6'b101111);
      joy_n = '1; mouse_port = 1'b1; step();
      check("handover_port_change", mouse_active, 2'b00);
      mouse_x = -9'sd64; mouse_strobe = 1'b1; step();
      mouse_strobe = 1'b0; str[1] = 1'b1; step();
      check("handover_active_p1", mouse_active, 2'b10);
      check("handover_p1_pins", port_n[11:6], 6'b110100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msx_input_ports.md
# msx_input_ports

Parametrised MSX general-purpose input-port adapter: maps host joysticks and one host mouse onto NPORTS MSX joystick ports, modelled as open-collector pins. In the MSX top level it sits between user_io (joystick, mouse) and emsx_top (pJoyA/pJoyB, pStra/pStrb). The top level converts each released pin to 'Z'. It succeeds the fixed two-port inline logic with:
- a selectable mouse port;
- saturated delta accumulation;
- a parametrised timeout.

## Interface
Parameters:
- NPORTS, 2, number of MSX ports (>=2)
- TIMEOUT, 100000, clk_sys cycles without a strobe edge before the nibble sequence resets

Ports:
- clk_sys  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- joy_n  in  NPORTS*6  host joystick bits, active-low, port p at [6p+5:6p]; bit0 R, 1 L, 2 D, 3 U, 4 fire1, 5 fire2
- mouse_x  in  9  signed X delta
- mouse_y  in  9  signed Y delta
- mouse_flags  in  8  bit0 left button, bit1 right button
- mouse_strobe  in  1  one-cycle new-packet pulse
- mouse_port  in  $clog2(NPORTS)  port the mouse is attached to
- str  in  NPORTS  MSX strobe (pin 8) per port, synchronous to clk_sys
- port_n  out  NPORTS*6  pin state, registered: 0 = pulled low, 1 = released
- mouse_active  out  NPORTS  one-hot, mouse mode on that port

## Operation
Joystick mode (every port except an active mouse port):
- port_n bit = 0 only when joy_n bit = 0 and str[p] = 0; otherwise 1.

Mouse enable (mouse_en), priority order:
- reset clears mouse_en;
- a change of mouse_port clears mouse_en and the nibble state;
- mouse_strobe sets mouse_en;
- any joy_n bit = 0 on the mouse port clears mouse_en.
- mouse_active[mouse_port] = mouse_en.

Mouse mode, mouse port only:
- port_n[5:4] = ~mouse_flags[1:0], registered, independent of str.
- port_n[3:0] carries the current nibble.

Deltas:
- dx = sat8(-mouse_x), dy = sat8(mouse_y).
- sat8 clamps to [-128, 127].
- Each lands in an 8-bit accumulator: acc_x and acc_y.

Nibble state machine: NIB_XH -> NIB_XL -> NIB_YH -> NIB_YL -> NIB_XH. It advances on each str edge (str != str_d) of the mouse port. The nibble emitted for the state held at the edge is:
- NIB_XH: acc_x[7:4]
- NIB_XL: acc_x[3:0]
- NIB_YH: acc_y[7:4]
- NIB_YL: acc_y[3:0]; both accumulators then clear

Timeout:
- Each edge reloads the counter to TIMEOUT.
- The counter decrements while nonzero.
- On the 1 -> 0 transition, state returns to NIB_XH.
- An edge in the same cycle as expiry wins: state advances and the counter reloads.

Simultaneous mouse_strobe and NIB_YL clear: accumulator = new delta. The new packet is never lost.

## Timing
- str sampled at cycle N, edge detected at N -> port_n updated at N+1. Strobe-to-data latency is 1 cycle.
- mouse_strobe at N -> accumulator updated at N+1 -> visible on the next edge.
- joy_n/str to port_n in joystick mode: 1 cycle.
- Reset values: port_n all 1, mouse_active 0, state NIB_XH, acc_x = acc_y = 0, counter 0, str_d = 0, mouse_en 0.
- Reset mid-sequence abandons the sequence. The next edge emits NIB_XH.

## Configuration
- MSX_MOUSE_ACCUM_EN defined: each strobe performs acc <= sat8(acc + delta).
- Undefined: each strobe performs acc <= delta (latest packet overwrites; legacy behaviour).
- Clear-on-NIB_YL and the simultaneous-event rule apply in both builds.

## Structure
- Package msx_input_pkg:
  - nibble state enum (NIB_XH, NIB_XL, NIB_YH, NIB_YL);
  - DELTA_W = 8;
  - function sat8.
- Sub-module msx_mouse_codec, one instance, holding:
  - accumulators;
  - edge detect;
  - nibble FSM;
  - timeout counter.
  The top of the block does per-port joystick gating and muxes the codec output onto mouse_port.

## Test plan
- Joystick: joy_n port 1 = 6'b111110, str[1] = 0 -> port_n[11:6] = 6'b111110 at N+1. With str[1] = 1 -> 6'b111111.
- Mouse sequence: strobe mouse_x = -5, mouse_y = 3, then toggle str[0] four times -> nibbles 0, 5, 0, 3. The fifth toggle yields 0 (cleared).
- Accumulation (EN defined): strobes x = -100, -100 -> acc_x = 127 (saturated). Undefined build -> acc_x = 100.
- Timeout: two edges, then TIMEOUT idle cycles -> the next edge emits NIB_XH. An edge at the expiry cycle advances normally.
- Handover: mouse_en on port 0, joy_n port 0 fire1 low -> mouse_active = 0, joystick gating. Setting mouse_port = 1 clears the state; the next strobe gives mouse_active = 2'b10.
- Collision: mouse_strobe in the same cycle as the NIB_YL edge -> subsequent NIB_XH shows the new packet's dx[7:4].
